game_round_manager: RTL and testbench
=====================================

Name: game_round_manager

Overview:
- Producer side of the game control handshake. Consumes game_enable / game_enable_posedge and generates game_finished back to the game control FSM.
- Sequences a Duck Hunt game: spawns ducks, tracks shots per duck, counts hits and misses per round, accumulates score, and decides when the game ends.
- Sits between game control and the duck/mouse logic. Score and counters feed the HUD and game-over screen.

Parameters:
- DUCKS_PER_ROUND, 10, ducks spawned per round (1..15)
- SHOTS_PER_DUCK, 3, shots available per duck (1..3)
- HITS_REQUIRED, 6, minimum hits in a round to advance to the next round
- MAX_ROUNDS, 5, last round number (1..15)
- POINTS_PER_HIT, 100, score increment per hit
- SPAWN_DELAY, 32500000, cycles between entering SPAWN_WAIT and duck_spawn (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- game_enable  in  1  level: game running
- game_enable_posedge  in  1  one-cycle pulse at game start
- shot_fired  in  1  one-cycle pulse per left-click shot
- duck_hit  in  1  one-cycle pulse: current duck shot
- duck_escaped  in  1  one-cycle pulse: current duck left screen
- game_finished  out  1  level: game over, held until rst
- duck_spawn  out  1  one-cycle pulse: launch new duck
- duck_active  out  1  high while in DUCK_ACTIVE
- fly_away  out  1  high in DUCK_ACTIVE when shots_left==0
- shots_left  out  2  remaining shots for current duck
- round_number  out  4  current round, 1-based (0 before first game)
- ducks_in_round  out  4  ducks resolved in current round
- hits_in_round  out  4  hits in current round
- score  out  16  total score, saturating

Behaviour:
- Reset: state=IDLE. All outputs 0.
- All outputs are registered. Input pulses are sampled on posedge clk.
- States: IDLE, SPAWN_WAIT, DUCK_ACTIVE, ROUND_END, FINISHED.
- IDLE:
  - On game_enable_posedge: clear score, ducks_in_round, hits_in_round, shots_left; set round_number=1; load delay counter; go to SPAWN_WAIT next cycle.
  - Otherwise hold all counters.
- SPAWN_WAIT:
  - Delay counter counts SPAWN_DELAY cycles from the state-entry cycle.
  - On the cycle the count completes: next cycle state=DUCK_ACTIVE, duck_spawn=1 for exactly that one cycle, shots_left=SHOTS_PER_DUCK.
  - shot_fired, duck_hit and duck_escaped are ignored here.
- DUCK_ACTIVE:
  - shot_fired with shots_left>0: shots_left decrements by 1. With shots_left==0 the shot is ignored.
  - fly_away = (shots_left==0). The duck module uses it and reports the result via duck_escaped.
  - duck_hit: hits_in_round+1; score+POINTS_PER_HIT, saturating at 0xFFFF; duck resolved.
  - duck_escaped: duck resolved as a miss.
  - Simultaneous duck_hit and duck_escaped: counted as a hit only.
  - Simultaneous shot_fired and duck_hit: both take effect.
  - On resolution: ducks_in_round+1. If the new value == DUCKS_PER_ROUND, go to ROUND_END; else go to SPAWN_WAIT with the delay counter reloaded.
- ROUND_END (single cycle):
  - If hits_in_round < HITS_REQUIRED, or round_number == MAX_ROUNDS: go to FINISHED.
  - Else: round_number+1; clear ducks_in_round and hits_in_round; go to SPAWN_WAIT.
- FINISHED:
  - game_finished=1 from the first cycle in this state.
  - score, round_number, ducks_in_round and hits_in_round are frozen.
  - All inputs, including game_enable and game_enable_posedge, are ignored.
  - Only rst leaves this state.
- Abort: game_enable==0 in SPAWN_WAIT, DUCK_ACTIVE or ROUND_END sends the block to IDLE next cycle.
  - Pending resolution in that cycle is discarded.
  - Counters and score are held; duck_active, fly_away and shots_left are cleared.
- rst mid-game: returns to IDLE with all outputs 0, regardless of state.

Test Plan (DUCKS_PER_ROUND=3, SHOTS_PER_DUCK=3, HITS_REQUIRED=2, MAX_ROUNDS=2, POINTS_PER_HIT=100, SPAWN_DELAY=4):
- Start:
  - Stimulus: rst, then game_enable=1 with game_enable_posedge pulse at cycle 0.
  - Required: round_number=1 at cycle 1; duck_spawn single pulse at cycle 5; shots_left=3; duck_active=1.
- Shots:
  - Stimulus: 4 shot_fired pulses, no hit.
  - Required: shots_left 3→2→1→0, then stays 0; fly_away=1 after the third shot.
  - Then duck_escaped: ducks_in_round=1, hits_in_round=0, score=0.
- Round advance:
  - Stimulus: hit 3 ducks in round 1.
  - Required: score=300; ROUND_END then round_number=2; ducks_in_round and hits_in_round cleared; game_finished stays 0.
- Fail round:
  - Stimulus: round 1 with 1 hit, 2 escapes.
  - Required: game_finished=1, held; score=100 and round_number=1 frozen; later game_enable_posedge has no effect.
- Final round and simultaneous events:
  - Stimulus: 2 rounds with 3 hits each, one hit pulsed together with duck_escaped.
  - Required: the simultaneous case counts as a hit; final score=600; game_finished=1 after round 2.
- Abort and reset:
  - Stimulus: deassert game_enable in DUCK_ACTIVE.
  - Required: IDLE next cycle; duck_active=0; score held.
  - Then assert rst in FINISHED: all outputs 0.

Source files
------------

// File: rtl/game_round_if.sv
// Game control / duck logic handshake bundle for the round manager.
// Every signal is a plain level or a one-cycle pulse; there is no ready/back-pressure.
interface game_round_if;
  logic       game_enable;
  logic       game_enable_posedge;
  logic       shot_fired;
  logic       duck_hit;
  logic       duck_escaped;
  logic       game_finished;
  logic       duck_spawn;
  logic       duck_active;
  logic       fly_away;
  logic [1:0] shots_left;
  logic [3:0] round_number;
  logic [3:0] ducks_in_round;
  logic [3:0] hits_in_round;
  logic [15:0] score;
  logic [2:0] state_dbg;

  modport master (
    output game_enable, game_enable_posedge, shot_fired, duck_hit, duck_escaped,
    input  game_finished, duck_spawn, duck_active, fly_away, shots_left,
           round_number, ducks_in_round, hits_in_round, score, state_dbg
  );

  modport slave (
    input  game_enable, game_enable_posedge, shot_fired, duck_hit, duck_escaped,
    output game_finished, duck_spawn, duck_active, fly_away, shots_left,
           round_number, ducks_in_round, hits_in_round, score, state_dbg
  );
endinterface

// File: rtl/game_round_manager.sv
// Duck Hunt round sequencer: spawns ducks, tracks shots, hits, rounds and score,
// and raises game_finished back to game control. All outputs are registered.
module game_round_manager #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int HITS_REQUIRED   = 6,
  parameter int MAX_ROUNDS      = 5,
  parameter int POINTS_PER_HIT  = 100,
  parameter int SPAWN_DELAY     = 32500000
) (
  input  logic         clk,
  input  logic         rst,
  game_round_if.slave  io
);

  localparam int CNT_W = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
  // Counter is loaded with SPAWN_DELAY-1 so the entry cycle is the first counted cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SPAWN_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SPAWN_WAIT  = 3'd1,
    DUCK_ACTIVE = 3'd2,
    ROUND_END   = 3'd3,
    FINISHED    = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             finished_r;
  logic             spawn_r;
  logic             active_r;
  logic             fly_r;
  logic [1:0]       shots_r;
  logic [3:0]       round_r;
  logic [3:0]       ducks_r;
  logic [3:0]       hits_r;
  logic [15:0]      score_r;

  logic [16:0] score_sum;
  logic [15:0] score_inc;
  logic [1:0]  shots_next;
  logic [3:0]  ducks_next;
  logic        resolved;

  always_comb begin
    score_sum  = {1'b0, score_r} + 17'(POINTS_PER_HIT);
    score_inc  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    shots_next = (io.shot_fired && (shots_r != 2'd0)) ? shots_r - 2'd1 : shots_r;
    ducks_next = ducks_r + 4'd1;
    resolved   = io.duck_hit | io.duck_escaped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      finished_r <= 1'b0;
      spawn_r    <= 1'b0;
      active_r   <= 1'b0;
      fly_r      <= 1'b0;
      shots_r    <= 2'd0;
      round_r    <= 4'd0;
      ducks_r    <= 4'd0;
      hits_r     <= 4'd0;
      score_r    <= 16'd0;
    end else begin
      spawn_r <= 1'b0;
      case (state)
        IDLE: begin
          if (io.game_enable_posedge) begin
            score_r <= 16'd0;
            ducks_r <= 4'd0;
            hits_r  <= 4'd0;
            shots_r <= 2'd0;
            round_r <= 4'd1;
            cnt     <= CNT_LOAD;
            state   <= SPAWN_WAIT;
          end
        end

        SPAWN_WAIT: begin
          if (!io.game_enable) begin
            state    <= IDLE;
            active_r <= 1'b0;
            fly_r    <= 1'b0;
            shots_r  <= 2'd0;
          end else if (cnt == '0) begin
            state    <= DUCK_ACTIVE;
            spawn_r  <= 1'b1;
            active_r <= 1'b1;
            fly_r    <= 1'b0;
            shots_r  <= 2'(SHOTS_PER_DUCK);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DUCK_ACTIVE: begin
          if (!io.game_enable) begin
            state    <= IDLE;
            active_r <= 1'b0;
            fly_r    <= 1'b0;
            shots_r  <= 2'd0;
          end else begin
            shots_r <= shots_next;
            fly_r   <= (shots_next == 2'd0);
            if (resolved) begin
              // A hit wins over a simultaneous escape report.
              ducks_r  <= ducks_next;
              active_r <= 1'b0;
              fly_r    <= 1'b0;
              if (io.duck_hit) begin
                hits_r  <= hits_r + 4'd1;
                score_r <= score_inc;
              end
              if (ducks_next == 4'(DUCKS_PER_ROUND)) begin
                state <= ROUND_END;
              end else begin
                cnt   <= CNT_LOAD;
                state <= SPAWN_WAIT;
              end
            end
          end
        end

        ROUND_END: begin
          if (!io.game_enable) begin
            state    <= IDLE;
            active_r <= 1'b0;
            fly_r    <= 1'b0;
            shots_r  <= 2'd0;
          end else if ((hits_r < 4'(HITS_REQUIRED)) || (round_r == 4'(MAX_ROUNDS))) begin
            finished_r <= 1'b1;
            state      <= FINISHED;
          end else begin
            round_r <= round_r + 4'd1;
            ducks_r <= 4'd0;
            hits_r  <= 4'd0;
            cnt     <= CNT_LOAD;
            state   <= SPAWN_WAIT;
          end
        end

        FINISHED: begin
          // Terminal until reset; every input is ignored.
          finished_r <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign io.game_finished  = finished_r;
  assign io.duck_spawn     = spawn_r;
  assign io.duck_active    = active_r;
  assign io.fly_away       = fly_r;
  assign io.shots_left     = shots_r;
  assign io.round_number   = round_r;
  assign io.ducks_in_round = ducks_r;
  assign io.hits_in_round  = hits_r;
  assign io.score          = score_r;
  assign io.state_dbg      = state;

endmodule

// File: tb/tb_game_round_manager.sv
// Directed, table-driven bench for game_round_manager with small game parameters.
module tb_game_round_manager;

  localparam int ST_IDLE = 0;
  localparam int ST_SW   = 1;
  localparam int ST_DA   = 2;
  localparam int ST_RE   = 3;
  localparam int ST_FIN  = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  game_round_if io ();

  game_round_manager #(
    .DUCKS_PER_ROUND(3),
    .SHOTS_PER_DUCK (3),
    .HITS_REQUIRED  (2),
    .MAX_ROUNDS     (2),
    .POINTS_PER_HIT (100),
    .SPAWN_DELAY    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, pos, shot, hit, esc;
    logic [2:0]  st;
    logic        fin, spawn, act, fly;
    logic [1:0]  shots;
    logic [3:0]  rnd, ducks, hits;
    logic [15:0] score;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(int en, int pos, int shot, int hit, int esc, int st,
                              int fin, int spawn, int act, int fly, int shots,
                              int rnd, int ducks, int hits, int score);
    vec_t r;
    r.en = 1'(en); r.pos = 1'(pos); r.shot = 1'(shot); r.hit = 1'(hit); r.esc = 1'(esc);
    r.st = 3'(st); r.fin = 1'(fin); r.spawn = 1'(spawn); r.act = 1'(act); r.fly = 1'(fly);
    r.shots = 2'(shots); r.rnd = 4'(rnd); r.ducks = 4'(ducks); r.hits = 4'(hits);
    r.score = 16'(score);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: apply inputs for one cycle, then settle past the edge before sampling.
  task automatic step(input logic en, input logic pos, input logic shot,
                      input logic hit, input logic esc);
    io.game_enable         = en;
    io.game_enable_posedge = pos;
    io.shot_fired          = shot;
    io.duck_hit            = hit;
    io.duck_escaped        = esc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, int'(io.state_dbg), ST_IDLE);
    chk({tag, "_fin"},   int'(io.game_finished), 0);
    chk({tag, "_spawn"}, int'(io.duck_spawn), 0);
    chk({tag, "_act"},   int'(io.duck_active), 0);
    chk({tag, "_fly"},   int'(io.fly_away), 0);
    chk({tag, "_shots"}, int'(io.shots_left), 0);
    chk({tag, "_round"}, int'(io.round_number), 0);
    chk({tag, "_ducks"}, int'(io.ducks_in_round), 0);
    chk({tag, "_hits"},  int'(io.hits_in_round), 0);
    chk({tag, "_score"}, int'(io.score), 0);
  endtask

  task automatic start_game();
    do_reset();
    step(1, 1, 0, 0, 0);
  endtask

  // Bounded wait for the next duck; the spawn pulse must coincide with the first active cycle.
  task automatic wait_duck(input string tag);
    for (int i = 0; i < 20 && !io.duck_active; i++) step(1, 0, 0, 0, 0);
    chk({tag, "_active"}, int'(io.duck_active), 1);
    chk({tag, "_spawn"},  int'(io.duck_spawn), 1);
    chk({tag, "_shots"},  int'(io.shots_left), 3);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    io.game_enable = 1'b0; io.game_enable_posedge = 1'b0;
    io.shot_fired = 1'b0; io.duck_hit = 1'b0; io.duck_escaped = 1'b0;

    // Start, spawn timing and shot counting, cycle by cycle
    //                en pos sh hit esc st     fin spn act fly sh rnd d h score
    tbl[0] = mk(1, 1, 0, 0, 0, ST_SW, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[1] = mk(1, 0, 0, 0, 0, ST_SW, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[2] = mk(1, 0, 0, 0, 0, ST_SW, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[3] = mk(1, 0, 0, 0, 0, ST_SW, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[4] = mk(1, 0, 0, 0, 0, ST_DA, 0, 1, 1, 0, 3, 1, 0, 0, 0);
    tbl[5] = mk(1, 0, 1, 0, 0, ST_DA, 0, 0, 1, 0, 2, 1, 0, 0, 0);
    tbl[6] = mk(1, 0, 1, 0, 0, ST_DA, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    tbl[7] = mk(1, 0, 1, 0, 0, ST_DA, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    tbl[8] = mk(1, 0, 1, 0, 0, ST_DA, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    tbl[9] = mk(1, 0, 0, 0, 1, ST_SW, 0, 0, 0, 0, 0, 1, 1, 0, 0);

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 10; i++) begin
      string tg;
      tg = $sformatf("vec%0d", i);
      step(tbl[i].en, tbl[i].pos, tbl[i].shot, tbl[i].hit, tbl[i].esc);
      chk({tg, "_state"}, int'(io.state_dbg),      int'(tbl[i].st));
      chk({tg, "_fin"},   int'(io.game_finished),  int'(tbl[i].fin));
      chk({tg, "_spawn"}, int'(io.duck_spawn),     int'(tbl[i].spawn));
      chk({tg, "_act"},   int'(io.duck_active),    int'(tbl[i].act));
      chk({tg, "_fly"},   int'(io.fly_away),       int'(tbl[i].fly));
      chk({tg, "_shots"}, int'(io.shots_left),     int'(tbl[i].shots));
      chk({tg, "_round"}, int'(io.round_number),   int'(tbl[i].rnd));
      chk({tg, "_ducks"}, int'(io.ducks_in_round), int'(tbl[i].ducks));
      chk({tg, "_hits"},  int'(io.hits_in_round),  int'(tbl[i].hits));
      chk({tg, "_score"}, int'(io.score),          int'(tbl[i].score));
    end

    // Round advance, then final round with shot+hit and hit+escape coincidences
    start_game();
    for (int d = 0; d < 3; d++) begin
      wait_duck($sformatf("r1d%0d", d));
      step(1, 0, 0, 1, 0);
      chk($sformatf("r1d%0d_hits", d), int'(io.hits_in_round), d + 1);
    end
    chk("r1_end_state", int'(io.state_dbg), ST_RE);
    chk("r1_end_score", int'(io.score), 300);
    step(1, 0, 0, 0, 0);
    chk("r2_state", int'(io.state_dbg), ST_SW);
    chk("r2_round", int'(io.round_number), 2);
    chk("r2_ducks", int'(io.ducks_in_round), 0);
    chk("r2_hits",  int'(io.hits_in_round), 0);
    chk("r2_fin",   int'(io.game_finished), 0);
    wait_duck("r2d0");
    step(1, 0, 1, 1, 0);
    chk("shot_hit_hits",  int'(io.hits_in_round), 1);
    chk("shot_hit_score", int'(io.score), 400);
    wait_duck("r2d1");
    step(1, 0, 0, 1, 0);
    wait_duck("r2d2");
    step(1, 0, 0, 1, 1);
    chk("hit_esc_hits",  int'(io.hits_in_round), 3);
    chk("hit_esc_ducks", int'(io.ducks_in_round), 3);
    chk("hit_esc_score", int'(io.score), 600);
    step(1, 0, 0, 0, 0);
    chk("final_state", int'(io.state_dbg), ST_FIN);
    chk("final_fin",   int'(io.game_finished), 1);
    chk("final_score", int'(io.score), 600);
    chk("final_round", int'(io.round_number), 2);

    // Failed round: 1 hit, 2 escapes, then inputs in FINISHED must change nothing
    start_game();
    wait_duck("fd0"); step(1, 0, 0, 1, 0);
    wait_duck("fd1"); step(1, 0, 0, 0, 1);
    wait_duck("fd2"); step(1, 0, 0, 0, 1);
    chk("fail_re_state", int'(io.state_dbg), ST_RE);
    step(1, 0, 0, 0, 0);
    chk("fail_fin", int'(io.game_finished), 1);
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1);
    chk("fail_hold_fin",   int'(io.game_finished), 1);
    chk("fail_hold_state", int'(io.state_dbg), ST_FIN);
    chk("fail_hold_score", int'(io.score), 100);
    chk("fail_hold_round", int'(io.round_number), 1);
    chk("fail_hold_ducks", int'(io.ducks_in_round), 3);
    chk("fail_hold_hits",  int'(io.hits_in_round), 1);
    chk("fail_hold_spawn", int'(io.duck_spawn), 0);
    rst = 1'b1;
    step(1, 0, 0, 0, 0);
    rst = 1'b0;
    check_all_zero("rst_fin");

    // Abort in DUCK_ACTIVE with a hit in the same cycle: hit discarded, score held
    start_game();
    wait_duck("ad0"); step(1, 0, 0, 1, 0);
    wait_duck("ad1");
    step(1, 0, 1, 0, 0);
    chk("abort_pre_shots", int'(io.shots_left), 2);
    step(0, 0, 0, 1, 0);
    chk("abort_state", int'(io.state_dbg), ST_IDLE);
    chk("abort_act",   int'(io.duck_active), 0);
    chk("abort_fly",   int'(io.fly_away), 0);
    chk("abort_shots", int'(io.shots_left), 0);
    chk("abort_score", int'(io.score), 100);
    chk("abort_ducks", int'(io.ducks_in_round), 1);
    chk("abort_hits",  int'(io.hits_in_round), 1);
    chk("abort_round", int'(io.round_number), 1);
    step(0, 0, 0, 0, 0);
    chk("idle_hold_score", int'(io.score), 100);
    chk("idle_hold_state", int'(io.state_dbg), ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
